// File: rtl/hpdcache_pkg.sv
// hpdcache_pkg: shared constants and types for the HPDcache directory
package hpdcache_pkg;
  localparam int HPDCACHE_SETS = 128;
  localparam int HPDCACHE_WAYS = 4;
  localparam int HPDCACHE_DIR_ENTRY_W = 32;
  localparam int HPDCACHE_DIR_STARVE_MAX = 4;
  typedef logic [$clog2(HPDCACHE_SETS)-1:0] hpdcache_dir_addr_t;
  typedef logic [HPDCACHE_WAYS-1:0] hpdcache_way_vector_t;
  typedef logic [HPDCACHE_DIR_ENTRY_W-1:0] hpdcache_dir_entry_t;
  typedef enum logic {SWEEP, RUN} dir_state_e;
endpackage

// File: rtl/hpdcache_dir_arb.sv
// hpdcache_dir_arb: refill-over-core fixed priority with a core starvation escape
module hpdcache_dir_arb
  import hpdcache_pkg::*;
#(
  parameter int STARVE_MAX = HPDCACHE_DIR_STARVE_MAX
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       run,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve;
  logic starved;
  assign starved = starve == SW'(STARVE_MAX);
  assign gnt[0] = en & req[0] & ~(req[1] & starved);
  assign gnt[1] = en & req[1] & ~gnt[0];
  always_ff @(posedge clk_i)
    if (!rst_ni || !req[1] || gnt[1]) starve <= '0;
    else if (run && !starved) starve <= starve + SW'(1);
endmodule

// File: rtl/hpdcache_dir_ctrl.sv
// hpdcache_dir_ctrl: directory init/flush sweeper and refill/core port arbiter
module hpdcache_dir_ctrl
  import hpdcache_pkg::*;
#(
  parameter int SETS = HPDCACHE_SETS,
  parameter int WAYS = HPDCACHE_WAYS,
  parameter int ENTRY_W = HPDCACHE_DIR_ENTRY_W,
  parameter int STARVE_MAX = HPDCACHE_DIR_STARVE_MAX,
  localparam int AW = $clog2(SETS),
  localparam int DW = WAYS * ENTRY_W
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  output logic            flush_done_o,
  output logic            init_done_o,
  input  logic            refill_req_i,
  output logic            refill_gnt_o,
  input  logic [WAYS-1:0] refill_we_i,
  input  logic [AW-1:0]   refill_set_i,
  input  logic [DW-1:0]   refill_wentry_i,
  output logic            refill_rvalid_o,
  input  logic            core_req_i,
  output logic            core_gnt_o,
  input  logic [WAYS-1:0] core_cs_i,
  input  logic [WAYS-1:0] core_we_i,
  input  logic [AW-1:0]   core_set_i,
  input  logic [DW-1:0]   core_wentry_i,
  output logic            core_rvalid_o,
  output logic [DW-1:0]   dir_rentry_o,
  output logic [AW-1:0]   dir_addr_o,
  output logic [WAYS-1:0] dir_cs_o,
  output logic [WAYS-1:0] dir_we_o,
  output logic [DW-1:0]   dir_wentry_o,
  input  logic [DW-1:0]   dir_rentry_i
);
  dir_state_e state;
  logic [AW-1:0] cnt;
  logic flushing, sweep, last;
  logic [1:0] gnt;
  logic [WAYS-1:0] cs, we;
  assign sweep = state == SWEEP;
  assign last = sweep && cnt == AW'(SETS - 1);
  hpdcache_dir_arb #(.STARVE_MAX(STARVE_MAX)) arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .run    (!sweep),
    .en     (!sweep && !flush_i),
    .req    ({core_req_i, refill_req_i}),
    .gnt    (gnt)
  );
  assign refill_gnt_o = gnt[0];
  assign core_gnt_o = gnt[1];
  assign flush_done_o = last & flushing;
  assign dir_rentry_o = dir_rentry_i;
  always_comb begin
    dir_addr_o = sweep ? cnt : gnt[0] ? refill_set_i : core_set_i;
    cs = (sweep || gnt[0]) ? '1 : gnt[1] ? core_cs_i : '0;
    we = sweep ? '1 : gnt[0] ? refill_we_i : gnt[1] ? core_we_i : '0;
    dir_wentry_o = sweep ? '0 : gnt[0] ? refill_wentry_i : core_wentry_i;
  end
  // The memarray must never see an enable while reset is asserted.
  assign dir_cs_o = cs & {WAYS{rst_ni}};
  assign dir_we_o = we & {WAYS{rst_ni}};
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      state <= SWEEP;
      cnt <= '0;
      flushing <= 1'b0;
      init_done_o <= 1'b0;
      refill_rvalid_o <= 1'b0;
      core_rvalid_o <= 1'b0;
    end else begin
      refill_rvalid_o <= gnt[0] && refill_we_i != '1;
      core_rvalid_o <= gnt[1] && |core_cs_i && core_we_i != core_cs_i;
      if (!sweep) begin
        if (flush_i) begin
          state <= SWEEP;
          flushing <= 1'b1;
        end
      end else begin
        cnt <= cnt + AW'(1);
        if (last) begin
          state <= RUN;
          init_done_o <= 1'b1;
          flushing <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_hpdcache_dir_ctrl.sv
// tb_hpdcache_dir_ctrl: directed checks of sweep, arbitration, starvation and read return
module tb_hpdcache_dir_ctrl;
  localparam int SETS = 8;
  localparam int WAYS = 4;
  localparam int EW = 32;
  localparam int AW = 3;
  localparam int DW = WAYS * EW;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic flush_done, init_done;
  logic refill_req = 1'b0;
  logic refill_gnt, refill_rvalid;
  logic [WAYS-1:0] refill_we = '0;
  logic [AW-1:0] refill_set = '0;
  logic [DW-1:0] refill_wentry = '0;
  logic core_req = 1'b0;
  logic core_gnt, core_rvalid;
  logic [WAYS-1:0] core_cs = '0;
  logic [WAYS-1:0] core_we = '0;
  logic [AW-1:0] core_set = '0;
  logic [DW-1:0] core_wentry = '0;
  logic [DW-1:0] dir_rentry_o, dir_wentry_o;
  logic [DW-1:0] dir_rentry = '0;
  logic [AW-1:0] dir_addr_o;
  logic [WAYS-1:0] dir_cs_o, dir_we_o;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hpdcache_dir_ctrl #(.SETS(SETS), .WAYS(WAYS), .ENTRY_W(EW), .STARVE_MAX(4)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .flush_i         (flush),
    .flush_done_o    (flush_done),
    .init_done_o     (init_done),
    .refill_req_i    (refill_req),
    .refill_gnt_o    (refill_gnt),
    .refill_we_i     (refill_we),
    .refill_set_i    (refill_set),
    .refill_wentry_i (refill_wentry),
    .refill_rvalid_o (refill_rvalid),
    .core_req_i      (core_req),
    .core_gnt_o      (core_gnt),
    .core_cs_i       (core_cs),
    .core_we_i       (core_we),
    .core_set_i      (core_set),
    .core_wentry_i   (core_wentry),
    .core_rvalid_o   (core_rvalid),
    .dir_rentry_o    (dir_rentry_o),
    .dir_addr_o      (dir_addr_o),
    .dir_cs_o        (dir_cs_o),
    .dir_we_o        (dir_we_o),
    .dir_wentry_o    (dir_wentry_o),
    .dir_rentry_i    (dir_rentry)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [12:0] got, exp;
    refill_req = 1'b1;
    core_req = 1'b1;
    core_cs = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    got = {dir_cs_o, dir_we_o, init_done, refill_gnt, core_gnt, refill_rvalid, core_rvalid};
    total++;
    if (got !== 13'b0) begin bad++; $display("FAIL reset_state got=%h exp=0", got); end
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < SETS; i++) begin
      @(negedge clk);
      got = {dir_addr_o, dir_cs_o, dir_we_o, refill_gnt, core_gnt};
      exp = {3'(i), 4'hf, 4'hf, 2'b00};
      total++;
      if (got !== exp || dir_wentry_o !== '0 || init_done !== 1'b0) begin
        bad++;
        $display("FAIL init_sweep[%0d] got=%h exp=%h init_done=%b", i, got, exp, init_done);
      end
      tick;
    end
    refill_req = 1'b0;
    core_req = 1'b0;
    @(negedge clk);
    total++;
    if ({init_done, refill_gnt, core_gnt, dir_cs_o} !== {3'b100, 4'h0}) begin
      bad++;
      $display("FAIL init_done got=%b exp=1000000", {init_done, refill_gnt, core_gnt, dir_cs_o});
    end
  endtask

  task automatic test_priority;
    logic [DW-1:0] rd;
    rd = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    tick;
    refill_req = 1'b1; refill_set = 3'd3; refill_we = '0;
    core_req = 1'b1; core_set = 3'd5; core_cs = '1; core_we = '0;
    @(negedge clk);
    total++;
    if ({refill_gnt, core_gnt, dir_addr_o, dir_cs_o, dir_we_o} !== {2'b10, 3'd3, 4'hf, 4'h0}) begin
      bad++;
      $display("FAIL prio_refill got=%h exp=%h", {refill_gnt, core_gnt, dir_addr_o, dir_cs_o, dir_we_o}, {2'b10, 3'd3, 4'hf, 4'h0});
    end
    tick;
    refill_req = 1'b0;
    @(negedge clk);
    total++;
    if ({refill_gnt, core_gnt, dir_addr_o, refill_rvalid, core_rvalid} !== {2'b01, 3'd5, 2'b10}) begin
      bad++;
      $display("FAIL prio_core got=%b exp=%b", {refill_gnt, core_gnt, dir_addr_o, refill_rvalid, core_rvalid}, {2'b01, 3'd5, 2'b10});
    end
    tick;
    core_req = 1'b0;
    dir_rentry = rd;
    @(negedge clk);
    total++;
    if ({refill_rvalid, core_rvalid, core_gnt, dir_cs_o} !== {3'b010, 4'h0} || dir_rentry_o !== rd) begin
      bad++;
      $display("FAIL core_read_return got=%b data=%h exp=0100000 data=%h", {refill_rvalid, core_rvalid, core_gnt, dir_cs_o}, dir_rentry_o, rd);
    end
  endtask

  task automatic test_starve;
    logic [1:0] exp;
    tick;
    refill_req = 1'b1; refill_we = '1;
    core_req = 1'b1; core_cs = '1; core_we = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      exp = (i == 4 || i == 9) ? 2'b01 : 2'b10;
      total++;
      if ({refill_gnt, core_gnt} !== exp) begin
        bad++;
        $display("FAIL starve[%0d] got=%b exp=%b", i, {refill_gnt, core_gnt}, exp);
      end
      tick;
    end
    refill_req = 1'b0;
    core_req = 1'b0;
  endtask

  task automatic test_rw;
    logic [DW-1:0] wd;
    wd = {4{32'h5a5a0001}};
    tick;
    core_req = 1'b1; core_cs = 4'b0010; core_we = 4'b0010; core_wentry = wd;
    @(negedge clk);
    total++;
    if ({core_gnt, refill_gnt, dir_cs_o, dir_we_o} !== {2'b10, 4'b0010, 4'b0010} || dir_wentry_o !== wd) begin
      bad++;
      $display("FAIL core_write got=%b exp=1000100010", {core_gnt, refill_gnt, dir_cs_o, dir_we_o});
    end
    tick;
    core_cs = '1; core_we = '0;
    @(negedge clk);
    total++;
    if ({core_gnt, core_rvalid, refill_rvalid, dir_cs_o, dir_we_o} !== {3'b100, 4'hf, 4'h0}) begin
      bad++;
      $display("FAIL write_no_rvalid got=%b exp=10011110000", {core_gnt, core_rvalid, refill_rvalid, dir_cs_o, dir_we_o});
    end
    tick;
    core_req = 1'b0;
    @(negedge clk);
    total++;
    if ({core_rvalid, refill_rvalid, core_gnt} !== 3'b100) begin
      bad++;
      $display("FAIL read_rvalid got=%b exp=100", {core_rvalid, refill_rvalid, core_gnt});
    end
    tick;
    @(negedge clk);
    total++;
    if (core_rvalid !== 1'b0) begin bad++; $display("FAIL rvalid_one_cycle got=%b exp=0", core_rvalid); end
  endtask

  task automatic test_flush;
    logic [12:0] got, exp;
    tick;
    core_req = 1'b1; core_cs = '1; core_we = '0;
    @(negedge clk);
    total++;
    if (core_gnt !== 1'b1) begin bad++; $display("FAIL pre_flush_gnt got=%b exp=1", core_gnt); end
    tick;
    flush = 1'b1;
    @(negedge clk);
    total++;
    if ({refill_gnt, core_gnt, core_rvalid, flush_done, dir_cs_o} !== {4'b0010, 4'h0}) begin
      bad++;
      $display("FAIL flush_cycle got=%b exp=00100000", {refill_gnt, core_gnt, core_rvalid, flush_done, dir_cs_o});
    end
    tick;
    flush = 1'b0;
    for (int k = 0; k < SETS; k++) begin
      @(negedge clk);
      got = {refill_gnt, core_gnt, core_rvalid, flush_done, init_done, dir_addr_o, dir_we_o};
      exp = {3'b000, k == SETS - 1, 1'b1, 3'(k), 4'hf};
      total++;
      if (got !== exp) begin bad++; $display("FAIL flush_sweep[%0d] got=%b exp=%b", k, got, exp); end
      tick;
      flush = (k == 2);
    end
    @(negedge clk);
    total++;
    if ({core_gnt, flush_done, dir_cs_o} !== {2'b10, 4'hf}) begin
      bad++;
      $display("FAIL post_flush_gnt got=%b exp=101111", {core_gnt, flush_done, dir_cs_o});
    end
    tick;
    core_req = 1'b0;
  endtask

  task automatic test_reset_mid_sweep;
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({dir_addr_o, init_done} !== {3'(i), 1'b0}) begin
        bad++;
        $display("FAIL pre_reset_sweep[%0d] got=%b exp=%b", i, {dir_addr_o, init_done}, {3'(i), 1'b0});
      end
      if (i < 3) tick;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({dir_cs_o, dir_we_o} !== 8'h0) begin bad++; $display("FAIL reset_forces_cs got=%h exp=00", {dir_cs_o, dir_we_o}); end
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < SETS; i++) begin
      @(negedge clk);
      total++;
      if ({dir_addr_o, dir_we_o, init_done} !== {3'(i), 4'hf, 1'b0}) begin
        bad++;
        $display("FAIL restart_sweep[%0d] got=%b exp=%b", i, {dir_addr_o, dir_we_o, init_done}, {3'(i), 4'hf, 1'b0});
      end
      tick;
    end
    @(negedge clk);
    total++;
    if (init_done !== 1'b1) begin bad++; $display("FAIL restart_init_done got=%b exp=1", init_done); end
  endtask

  initial begin
    test_reset;
    test_priority;
    test_starve;
    test_rw;
    test_flush;
    test_reset_mid_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
